serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow into the next bit.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor (diff = a - b), LSB first, one full_subtractor cell.
// Optional signed-overflow output when SERIAL_SUB_OVF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// SHIFT | one bit step per cycle, WIDTH steps total
// DONE  | one-cycle done pulse; diff/borrow_out valid
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             borrow;
  logic             d_bit, b_next;
  logic             last_step;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;
`endif

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (b_next)
  );

  assign last_step = (state == SHIFT) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt    <= '0;
      a_sr   <= a;
      b_sr   <= b;
      borrow <= 1'b0;
    end else if (state == SHIFT) begin
      cnt    <= cnt + 1'b1;
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {d_bit, res_sr[WIDTH-1:1]};
      borrow <= b_next;
    end
  end

  // Result registers only move on the final step so they hold between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (last_step) begin
      diff       <= {d_bit, res_sr[WIDTH-1:1]};
      borrow_out <= b_next;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are kept from accept time since a_sr/b_sr are shifted out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (last_step) begin
      ovf <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8); checks ovf when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf        (ovf),
`endif
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cycle = 0;
  int   done_cnt = 0;
  int   last_done_cycle = -1;
  bit   spacing_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp_v, cycle);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.diff   = x - y;
    e.borrow = (x < y);
    e.ovf    = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
    return e;
  endfunction

  always @(posedge clk) cycle++;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done && rst_n) begin
      done_cnt++;
      if (spacing_en && last_done_cycle >= 0)
        check("done_spacing", cycle - last_done_cycle, W + 2);
      last_done_cycle = cycle;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("diff", diff, e.diff);
        check("borrow_out", borrow_out, e.borrow);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", ovf, e.ovf);
`endif
      end
    end
  end

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, output int acc_cycle);
    int g;
    g = 0;
    @(negedge clk);
    while (busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (busy) check("idle_timeout", 1, 0);
    a = x;
    b = y;
    start = 1'b1;
    sb_q.push_back(model(x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    acc_cycle = cycle;
  endtask

  task automatic wait_done(input int acc_cycle, input bit check_lat);
    int g;
    g = 0;
    do begin
      @(posedge clk);
      #2;
      g++;
    end while (!done && g < 40);
    if (!done) check("done_timeout", 0, 1);
    else if (check_lat) check("latency", cycle - acc_cycle + 1, W + 1);
  endtask

  initial begin
    int c0, d0, g;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    launch(8'h5A, 8'h21, c0);
    check("busy_after_accept", busy, 1);
    wait_done(c0, 1'b1);
    launch(8'h10, 8'h20, c0);
    wait_done(c0, 1'b1);
    launch(8'h80, 8'h01, c0);
    wait_done(c0, 1'b1);

    // start re-pulsed during SHIFT and during DONE with other operands
    d0 = done_cnt;
    launch(8'h3C, 8'h0F, c0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(c0, 1'b1);
    a = 8'h11; b = 8'h22; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    check("single_done", done_cnt - d0, 1);
    check("idle_after_ignored", busy, 0);

    // reset in the middle of an operation
    launch(8'h77, 8'h22, c0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_diff", diff, 0);
    check("midrst_borrow", borrow_out, 0);
    sb_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    check("no_done_after_rst", done_cnt - d0, 0);
    launch(8'hFF, 8'hFF, c0);
    wait_done(c0, 1'b1);

    // back-to-back with start held high
    repeat (2) @(posedge clk);
    last_done_cycle = -1;
    spacing_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      g = 0;
      @(negedge clk);
      while (busy && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (busy) begin
        check("b2b_idle_timeout", 1, 0);
        break;
      end
      a = W'($urandom);
      b = W'($urandom);
      start = 1'b1;
      sb_q.push_back(model(a, b));
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    g = 0;
    while (sb_q.size() != 0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    #2;
    spacing_en = 1'b0;
    check("sb_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
